// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Hard-wired zero register: writes to it are swallowed.
    localparam reg_addr_t X0 = '0;

    // Which writeback requester owns the write port.
    typedef enum logic {
        GRANT_EX = 1'b0,
        GRANT_LD = 1'b1
    } grant_e;

    // One candidate write for the register file port.
    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback/load/decode signal bundle of regfile_wb_sched.
// Optional forwarding outputs exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_sched_if #(
    parameter int MAX_LD = 4
);
    import regfile_wb_pkg::*;

    localparam int CNT_W = $clog2(MAX_LD + 1);

    // Execute-stage writeback
    logic       ex_valid;
    logic       ex_ready;
    reg_addr_t  ex_rd;
    xlen_t      ex_data;

    // Load issue from the memory stage
    logic       ld_issue;
    logic       ld_issue_ready;
    reg_addr_t  ld_issue_rd;

    // Load return
    logic       ld_valid;
    logic       ld_ready;
    reg_addr_t  ld_rd;
    xlen_t      ld_data;

    // Register file write port
    reg_addr_t  Rw;
    xlen_t      busW;
    logic       RegWr;

    // Decode hazard query
    reg_addr_t  Ra;
    reg_addr_t  Rb;
    logic       hazA;
    logic       hazB;

    // Status
    logic [CNT_W-1:0] ld_cnt;
    logic             err;

`ifdef REGFILE_WB_BYPASS_EN
    logic  fwdA_hit;
    logic  fwdB_hit;
    xlen_t fwdA_data;
    xlen_t fwdB_data;

    modport master (
        output ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data, Ra, Rb,
        input  ex_ready, ld_issue_ready, ld_ready, Rw, busW, RegWr,
               hazA, hazB, ld_cnt, err,
               fwdA_hit, fwdB_hit, fwdA_data, fwdB_data
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data, Ra, Rb,
        output ex_ready, ld_issue_ready, ld_ready, Rw, busW, RegWr,
               hazA, hazB, ld_cnt, err,
               fwdA_hit, fwdB_hit, fwdA_data, fwdB_data
    );
`else
    modport master (
        output ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data, Ra, Rb,
        input  ex_ready, ld_issue_ready, ld_ready, Rw, busW, RegWr,
               hazA, hazB, ld_cnt, err
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data, Ra, Rb,
        output ex_ready, ld_issue_ready, ld_ready, Rw, busW, RegWr,
               hazA, hazB, ld_cnt, err
    );
`endif

endinterface

// File: rtl/regfile_wb_sched_arb.sv
// Two-way round-robin arbiter between the execute and load-return requesters.
// A tie is won by whichever requester did not receive the most recent grant.
module wb_rr_arb
    import regfile_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ex,
    input  logic req_ld,
    output logic gnt_ex,
    output logic gnt_ld
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // Grant selection and the next value of the fairness pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_ex       = 1'b0;
        gnt_ld       = 1'b0;
        last_grant_d = last_grant_q;

        if (req_ex && req_ld) begin
            if (last_grant_q == GRANT_LD) begin
                gnt_ex = 1'b1;
            end else begin
                gnt_ld = 1'b1;
            end
        end else begin
            gnt_ex = req_ex;
            gnt_ld = req_ld;
        end

        if (gnt_ex) begin
            last_grant_d = GRANT_EX;
        end else if (gnt_ld) begin
            last_grant_d = GRANT_LD;
        end
    end

    // Fairness pointer register; starting at LD hands the first tie to EX.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            last_grant_q <= GRANT_LD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler for the RV32I register file: merges execute and
// load-return writebacks onto one write port, tracks pending loads for
// decode hazards and WAW ordering.
// Optional same-cycle forwarding: define REGFILE_WB_BYPASS_EN.
module regfile_wb_sched
    import regfile_wb_pkg::*;
#(
    parameter int MAX_LD = 4
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_sched_if.slave bus
);

    localparam int               CNT_W   = $clog2(MAX_LD + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [CNT_W-1:0]    ld_cnt_q;
    logic [CNT_W-1:0]    ld_cnt_d;
    logic                err_q;

    logic    ex_waw;
    logic    req_ex;
    logic    req_ld;
    logic    gnt_ex;
    logic    gnt_ld;
    logic    ld_bad;
    logic    commit_ok;
    logic    commit_err;
    logic    issue_room;
    logic    issue_block;
    logic    issue_rdy;
    logic    issue_fire;
    wb_req_t wr;
    logic    wr_en;

    // EX must wait behind an outstanding load to the same register.
    assign ex_waw = pend_q[bus.ex_rd] && (bus.ex_rd != X0);
    assign req_ex = !rst && bus.ex_valid && !ex_waw;
    assign req_ld = !rst && bus.ld_valid;

    wb_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_ex (req_ex),
        .req_ld (req_ld),
        .gnt_ex (gnt_ex),
        .gnt_ld (gnt_ld)
    );

    // A returning load is bogus if nothing is outstanding or its register
    // was never marked pending; it still completes its handshake.
    assign ld_bad     = (ld_cnt_q == '0) || ((bus.ld_rd != X0) && !pend_q[bus.ld_rd]);
    assign commit_ok  = gnt_ld && !ld_bad;
    assign commit_err = gnt_ld && ld_bad;

    // A good commit this cycle frees a slot, so a full counter can still
    // accept an issue in the same cycle.
    assign issue_room  = (ld_cnt_q < MAX_CNT) || commit_ok;
    assign issue_block = pend_q[bus.ld_issue_rd] && (bus.ld_issue_rd != X0);
    assign issue_rdy   = !rst && issue_room && !issue_block;
    assign issue_fire  = bus.ld_issue && issue_rdy;

    // Write-port mux driven straight from the grant.
    always_comb begin
        wr    = '0;
        wr_en = 1'b0;
        if (gnt_ex) begin
            wr.rd   = bus.ex_rd;
            wr.data = bus.ex_data;
            wr_en   = (bus.ex_rd != X0);
        end else if (gnt_ld) begin
            wr.rd   = bus.ld_rd;
            wr.data = bus.ld_data;
            wr_en   = (bus.ld_rd != X0) && !ld_bad;
        end
    end

    // Next scoreboard and outstanding-load count.
    always_comb begin
        pend_d   = pend_q;
        ld_cnt_d = ld_cnt_q;
        if (commit_ok) begin
            pend_d[bus.ld_rd] = 1'b0;
        end
        if (issue_fire) begin
            pend_d[bus.ld_issue_rd] = 1'b1;
        end
        pend_d[X0] = 1'b0;

        case ({issue_fire, commit_ok})
            2'b10:   ld_cnt_d = ld_cnt_q + ONE;
            2'b01:   ld_cnt_d = ld_cnt_q - ONE;
            default: ld_cnt_d = ld_cnt_q;
        endcase
    end

    // Scoreboard, counter and sticky error registers.
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is control state, not a data array, so it must be reset; a stale bit would stall decode forever.
        if (rst) begin
            pend_q   <= '0;
            ld_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            ld_cnt_q <= ld_cnt_d;
            if (commit_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ex_ready       = gnt_ex;
    assign bus.ld_ready       = gnt_ld;
    assign bus.ld_issue_ready = issue_rdy;
    assign bus.Rw             = wr.rd;
    assign bus.busW           = wr.data;
    assign bus.RegWr          = wr_en;
    assign bus.ld_cnt         = ld_cnt_q;
    assign bus.err            = err_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // A write landing this cycle satisfies the read, so the hazard drops.
    assign fwd_a         = wr_en && (wr.rd == bus.Ra);
    assign fwd_b         = wr_en && (wr.rd == bus.Rb);
    assign bus.fwdA_hit  = fwd_a;
    assign bus.fwdB_hit  = fwd_b;
    assign bus.fwdA_data = wr.data;
    assign bus.fwdB_data = wr.data;
    assign bus.hazA      = pend_q[bus.Ra] && !fwd_a;
    assign bus.hazB      = pend_q[bus.Rb] && !fwd_b;
`else
    assign bus.hazA = pend_q[bus.Ra];
    assign bus.hazB = pend_q[bus.Rb];
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a scoreboard model.
module tb_regfile_wb_sched;
    import regfile_wb_pkg::*;

    localparam int MAX_LD = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_sched_if #(.MAX_LD(MAX_LD)) bus ();

    regfile_wb_sched #(.MAX_LD(MAX_LD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ex_valid;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        ld_issue;
        logic [4:0]  ld_issue_rd;
        logic        ld_valid;
        logic [4:0]  ld_rd;
        logic [31:0] ld_data;
        logic [4:0]  ra;
        logic [4:0]  rb;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        ex_ready;
        logic        ld_ready;
        logic        issue_ready;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        haz_a;
        logic        haz_b;
        int          cnt;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input bit exv, input int exrd, input int exd,
                                 input bit iss, input int issrd,
                                 input bit ldv, input int ldrd, input int ldd,
                                 input int ra, input int rb);
        stim_t s;
        s.ex_valid    = exv;
        s.ex_rd       = 5'(exrd);
        s.ex_data     = 32'(exd);
        s.ld_issue    = iss;
        s.ld_issue_rd = 5'(issrd);
        s.ld_valid    = ldv;
        s.ld_rd       = 5'(ldrd);
        s.ld_data     = 32'(ldd);
        s.ra          = 5'(ra);
        s.rb          = 5'(rb);
        return s;
    endfunction

    function automatic void addv(input stim_t s, input bit exr, input bit ldr, input bit ir,
                                 input bit we, input int rw, input int busw,
                                 input bit ha, input bit hb, input int cnt, input bit err);
        vec_t v;
        v.s = s; v.ex_ready = exr; v.ld_ready = ldr; v.issue_ready = ir;
        v.regwr = we; v.rw = 5'(rw); v.busw = 32'(busw);
        v.haz_a = ha; v.haz_b = hb; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic drive(input stim_t s);
        bus.ex_valid    = s.ex_valid;
        bus.ex_rd       = s.ex_rd;
        bus.ex_data     = s.ex_data;
        bus.ld_issue    = s.ld_issue;
        bus.ld_issue_rd = s.ld_issue_rd;
        bus.ld_valid    = s.ld_valid;
        bus.ld_rd       = s.ld_rd;
        bus.ld_data     = s.ld_data;
        bus.Ra          = s.ra;
        bus.Rb          = s.rb;
    endtask

    // Advance one clock: wait out the sample point, then the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_pend[32];
    int m_cnt;
    bit m_err;
    bit m_ex_last;   // EX received the most recent grant

    typedef struct {
        bit          ex_win;
        bit          ld_win;
        bit          ld_good;
        bit          issue_ready;
        bit          regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        bit          haz_a;
        bit          haz_b;
    } exp_t;

    function automatic exp_t model_eval(input stim_t s, input bit r);
        exp_t e;
        bit ex_ok, ld_ok;
        e = '{default: 0};
        ex_ok = !r && s.ex_valid && !(s.ex_rd != 0 && m_pend[s.ex_rd]);
        ld_ok = !r && s.ld_valid;
        if (ex_ok && ld_ok) begin
            e.ex_win = !m_ex_last;
            e.ld_win = m_ex_last;
        end else begin
            e.ex_win = ex_ok;
            e.ld_win = ld_ok;
        end
        e.ld_good = (m_cnt > 0) && (s.ld_rd == 0 || m_pend[s.ld_rd]);
        e.issue_ready = !r && (m_cnt < MAX_LD || (e.ld_win && e.ld_good))
                        && !(s.ld_issue_rd != 0 && m_pend[s.ld_issue_rd]);
        e.rw = 0;
        e.busw = 0;
        if (e.ex_win) begin
            e.regwr = (s.ex_rd != 0);
            e.rw    = s.ex_rd;
            e.busw  = s.ex_data;
        end else if (e.ld_win) begin
            e.regwr = (s.ld_rd != 0) && e.ld_good;
            e.rw    = s.ld_rd;
            e.busw  = s.ld_data;
        end
        e.haz_a = m_pend[s.ra] && !(BYP && e.regwr && e.rw == s.ra);
        e.haz_b = m_pend[s.rb] && !(BYP && e.regwr && e.rw == s.rb);
        return e;
    endfunction

    task automatic model_step(input stim_t s, input bit r, input exp_t e);
        if (r) begin
            foreach (m_pend[k]) m_pend[k] = 1'b0;
            m_cnt     = 0;
            m_err     = 1'b0;
            m_ex_last = 1'b0;
        end else begin
            if (e.ex_win) m_ex_last = 1'b1;
            else if (e.ld_win) m_ex_last = 1'b0;
            if (e.ld_win) begin
                if (e.ld_good) begin
                    if (s.ld_rd != 0) m_pend[s.ld_rd] = 1'b0;
                    m_cnt--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (s.ld_issue && e.issue_ready) begin
                if (s.ld_issue_rd != 0) m_pend[s.ld_issue_rd] = 1'b1;
                m_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;

        // ---------------- reset state ----------------
        drive(mk(1, 3, 32'h55, 1, 4, 1, 6, 32'h66, 0, 0));
        @(negedge clk);
        check("rst ex_ready", 32'(bus.ex_ready), 0);
        check("rst ld_ready", 32'(bus.ld_ready), 0);
        check("rst issue_ready", 32'(bus.ld_issue_ready), 0);
        check("rst RegWr", 32'(bus.RegWr), 0);
        check("rst Rw", 32'(bus.Rw), 0);
        check("rst busW", bus.busW, 0);
        tick();
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        @(negedge clk);
        check("post-rst ld_cnt", 32'(bus.ld_cnt), 0);
        check("post-rst err", 32'(bus.err), 0);
        check("post-rst hazA", 32'(bus.hazA), 0);
        tick();
        do_reset();

        // ---------------- directed vector table ----------------
        //          inputs                                              exr ldr ir we rw busw         ha hb cnt err
        addv(mk(0,0,0,     0,0, 0,0,0,            5,0),                 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
        addv(mk(0,0,0,     1,5, 0,0,0,            5,0),                 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
        addv(mk(0,0,0,     0,0, 0,0,0,            5,0),                 0, 0, 1, 0, 0, 0,            1, 0, 1, 0);
        addv(mk(0,0,0,     0,0, 1,5,32'hDEADBEEF, 5,0),                 0, 1, 1, 1, 5, 32'hDEADBEEF, 1, 0, 1, 0);
        addv(mk(0,0,0,     0,0, 0,0,0,            5,0),                 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
        addv(mk(0,0,0,     1,7, 0,0,0,            0,0),                 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
        addv(mk(1,7,32'h77,0,0, 0,0,0,            7,0),                 0, 0, 1, 0, 0, 0,            1, 0, 1, 0);
        addv(mk(1,7,32'h77,0,0, 1,7,32'h700,      7,0),                 0, 1, 1, 1, 7, 32'h700,      1, 0, 1, 0);
        addv(mk(1,7,32'h77,0,0, 0,0,0,            7,0),                 1, 0, 1, 1, 7, 32'h77,       0, 0, 0, 0);
        addv(mk(0,0,0,     1,1, 0,0,0,            0,0),                 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
        addv(mk(0,0,0,     1,2, 0,0,0,            0,0),                 0, 0, 1, 0, 0, 0,            0, 0, 1, 0);
        addv(mk(0,0,0,     1,3, 0,0,0,            0,0),                 0, 0, 1, 0, 0, 0,            0, 0, 2, 0);
        addv(mk(0,0,0,     1,4, 0,0,0,            0,0),                 0, 0, 1, 0, 0, 0,            0, 0, 3, 0);
        addv(mk(0,0,0,     1,8, 0,0,0,            0,3),                 0, 0, 0, 0, 0, 0,            0, 1, 4, 0);
        addv(mk(0,0,0,     1,8, 1,3,32'h33,       0,0),                 0, 1, 1, 1, 3, 32'h33,       0, 0, 4, 0);
        addv(mk(0,0,0,     1,3, 0,0,0,            3,8),                 0, 0, 0, 0, 0, 0,            0, 1, 4, 0);
        addv(mk(0,0,0,     0,0, 1,9,32'h99,       0,0),                 0, 1, 0, 0, 0, 0,            0, 0, 4, 0);
        addv(mk(0,0,0,     0,0, 0,0,0,            0,0),                 0, 0, 0, 0, 0, 0,            0, 0, 4, 1);
        addv(mk(0,0,0,     0,0, 0,0,0,            8,0),                 0, 0, 0, 0, 0, 0,            1, 0, 4, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic exp_ha, exp_hb;
            v = vecs[i];
            drive(v.s);
            @(negedge clk);
            exp_ha = v.haz_a && !(BYP && v.regwr && v.rw == v.s.ra);
            exp_hb = v.haz_b && !(BYP && v.regwr && v.rw == v.s.rb);
            check($sformatf("v%0d ex_ready", i), 32'(bus.ex_ready), 32'(v.ex_ready));
            check($sformatf("v%0d ld_ready", i), 32'(bus.ld_ready), 32'(v.ld_ready));
            check($sformatf("v%0d issue_ready", i), 32'(bus.ld_issue_ready), 32'(v.issue_ready));
            check($sformatf("v%0d RegWr", i), 32'(bus.RegWr), 32'(v.regwr));
            if (v.regwr) begin
                check($sformatf("v%0d Rw", i), 32'(bus.Rw), 32'(v.rw));
                check($sformatf("v%0d busW", i), bus.busW, v.busw);
            end
            check($sformatf("v%0d hazA", i), 32'(bus.hazA), 32'(exp_ha));
            check($sformatf("v%0d hazB", i), 32'(bus.hazB), 32'(exp_hb));
            check($sformatf("v%0d ld_cnt", i), 32'(bus.ld_cnt), 32'(v.cnt));
            check($sformatf("v%0d err", i), 32'(bus.err), 32'(v.err));
`ifdef REGFILE_WB_BYPASS_EN
            check($sformatf("v%0d fwdA_hit", i), 32'(bus.fwdA_hit), 32'(v.regwr && v.rw == v.s.ra));
`endif
            tick();
        end

        // err is sticky until reset
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        @(negedge clk);
        check("err sticky", 32'(bus.err), 1);
        tick();
        do_reset();
        @(negedge clk);
        check("err cleared by rst", 32'(bus.err), 0);
        tick();

        // ---------------- tie: grants alternate EX, LD, EX, LD ----------------
        drive(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        tick();
        for (int c = 0; c < 4; c++) begin
            bit want_ex;
            want_ex = (c % 2) == 0;
            drive(mk(1, 1, 32'h11 + c, 0, 0, 1, 2, 32'h22 + c, 0, 0));
            @(negedge clk);
            check($sformatf("tie%0d ex_ready", c), 32'(bus.ex_ready), 32'(want_ex));
            check($sformatf("tie%0d ld_ready", c), 32'(bus.ld_ready), 32'(!want_ex));
            if (c == 0) begin
                check("tie0 Rw", 32'(bus.Rw), 1);
                check("tie0 busW", bus.busW, 32'h11);
            end
            if (c == 1) begin
                check("tie1 Rw", 32'(bus.Rw), 2);
                check("tie1 busW", bus.busW, 32'h23);
            end
            tick();
        end
        do_reset();

        // ---------------- write to x0 and forwarding ----------------
        drive(mk(1, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("x0 ex_ready", 32'(bus.ex_ready), 1);
        check("x0 RegWr", 32'(bus.RegWr), 0);
`ifdef REGFILE_WB_BYPASS_EN
        check("x0 fwdA_hit", 32'(bus.fwdA_hit), 0);
`endif
        tick();
        drive(mk(1, 10, 32'h1234, 0, 0, 0, 0, 0, 10, 11));
        @(negedge clk);
        check("rd10 RegWr", 32'(bus.RegWr), 1);
        check("rd10 busW", bus.busW, 32'h1234);
`ifdef REGFILE_WB_BYPASS_EN
        check("fwdA_hit", 32'(bus.fwdA_hit), 1);
        check("fwdA_data", bus.fwdA_data, 32'h1234);
        check("fwdB_hit", 32'(bus.fwdB_hit), 0);
`endif
        tick();

        // ---------------- reset mid-operation discards pending loads ----------------
        drive(mk(0, 0, 0, 1, 6, 0, 0, 0, 6, 0));
        tick();
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 1, 6, 32'h66, 6, 0));
        @(negedge clk);
        check("midrst hazA", 32'(bus.hazA), 0);
        check("midrst ld_ready", 32'(bus.ld_ready), 1);
        check("midrst RegWr", 32'(bus.RegWr), 0);
        tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("midrst err", 32'(bus.err), 1);
        tick();

        // ---------------- randomized run against the model ----------------
        do_reset();
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        m_cnt = 0; m_err = 1'b0; m_ex_last = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            stim_t s;
            exp_t  e;
            bit    r;
            int    cands[$];
            r = ($urandom_range(63) == 0);
            s = mk($urandom_range(1), $urandom_range(7), $urandom, $urandom_range(1),
                   $urandom_range(7), ($urandom_range(9) < 4), $urandom_range(7), $urandom,
                   $urandom_range(7), $urandom_range(7));
            for (int k = 1; k < 32; k++) if (m_pend[k]) cands.push_back(k);
            if (cands.size() > 0 && $urandom_range(3) != 0)
                s.ld_rd = 5'(cands[$urandom_range(cands.size() - 1)]);
            rst = r;
            drive(s);
            @(negedge clk);
            e = model_eval(s, r);
            check("rnd ex_ready", 32'(bus.ex_ready), 32'(e.ex_win));
            check("rnd ld_ready", 32'(bus.ld_ready), 32'(e.ld_win));
            check("rnd issue_ready", 32'(bus.ld_issue_ready), 32'(e.issue_ready));
            check("rnd RegWr", 32'(bus.RegWr), 32'(e.regwr));
            if (e.regwr || r) begin
                check("rnd Rw", 32'(bus.Rw), 32'(e.rw));
                check("rnd busW", bus.busW, e.busw);
            end
            check("rnd hazA", 32'(bus.hazA), 32'(e.haz_a));
            check("rnd hazB", 32'(bus.hazB), 32'(e.haz_b));
            check("rnd ld_cnt", 32'(bus.ld_cnt), 32'(m_cnt));
            check("rnd err", 32'(bus.err), 32'(m_err));
            @(posedge clk);
            model_step(s, r, e);
            #1;
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
